// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state/op encodings and the log2 helper for the SRAM controller
package sram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: beat/wait counters stepping through BEATS beats of L cycles each
module sram_beat_timer #(
    parameter int BEATS = 2,
    parameter int L     = 2,
    parameter int BW    = 1,
    parameter int WW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    output logic [BW-1:0] b,
    output logic [WW-1:0] w,
    output logic          beat_last_cycle,
    output logic          txn_last_cycle
);
    assign beat_last_cycle = en && (w == WW'(L - 1));
    assign txn_last_cycle  = beat_last_cycle && (b == BW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst || start) begin
            b <= '0;
            w <= '0;
        end else if (en) begin
            w <= beat_last_cycle ? '0 : w + WW'(1);
            if (beat_last_cycle) b <= txn_last_cycle ? '0 : b + BW'(1);
        end
    end
endmodule

// File: rtl/sram_ctrl_multibeat.sv
// sram_ctrl_multibeat: splits a DATA_W access into SRAM_DQ_W beats on an async SRAM,
// stalling the requester via ready until the whole transaction is done.
module sram_ctrl_multibeat
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      write_data,
    output logic [DATA_W-1:0]      read_data,
    output logic                   ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);
    localparam int BEATS      = DATA_W / SRAM_DQ_W;
    localparam int L          = WAIT_CYCLES + 1;
    localparam int BYTE_SHIFT = clog2(SRAM_DQ_W / 8);
    localparam int BW         = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
    localparam int WW         = clog2(L);

    state_t                 r_state;
    op_t                    r_op;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic                   r_we_n;
    logic                   r_oe_n;
    logic                   r_dq_oe;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic [BW-1:0]          w_b;
    logic [WW-1:0]          w_w;
    logic                   w_beat_last;
    logic                   w_txn_last;
    logic                   w_req;
    logic                   w_start;
    logic                   w_en;

    assign w_req     = rd_en || wr_en;
    assign w_start   = (r_state == IDLE) && w_req;
    assign w_en      = (r_state == ACCESS);
    assign ready     = (r_state == DONE) || ((r_state == IDLE) && !w_req);
    assign read_data = r_rdata;
    assign SRAM_ADDR = r_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    // r_wdata is shifted down one slice per beat, so the current slice is always in the LSBs
    assign SRAM_DQ   = r_dq_oe ? r_wdata[SRAM_DQ_W-1:0] : 'z;

    sram_beat_timer #(.BEATS(BEATS), .L(L), .BW(BW), .WW(WW)) u_timer (
        .clk(clk),
        .rst(rst),
        .start(w_start),
        .en(w_en),
        .b(w_b),
        .w(w_w),
        .beat_last_cycle(w_beat_last),
        .txn_last_cycle(w_txn_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_state <= ACCESS;
                    r_op    <= wr_en ? OP_WR : OP_RD;
                    r_addr  <= SRAM_ADDR_W'(address >> BYTE_SHIFT);
                    r_wdata <= write_data;
                    r_we_n  <= !wr_en;
                    r_oe_n  <= wr_en;
                    r_dq_oe <= wr_en;
                end
                ACCESS: begin
                    if (r_op == OP_RD && w_beat_last) r_rdata[w_b*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
                    if (w_txn_last) begin
                        r_state <= DONE;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                    end else if (w_beat_last) begin
                        r_addr  <= r_addr + SRAM_ADDR_W'(1);
                        r_wdata <= r_wdata >> SRAM_DQ_W;
                        r_we_n  <= (r_op != OP_WR);
                    end else begin
                        // release WE_N one cycle early so address/data are held past its rising edge
                        r_we_n  <= (r_op != OP_WR) || (w_w == WW'(L - 2));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl_multibeat.sv
// tb_sram_ctrl_multibeat: scoreboard bench for the default and a 64-bit/4-cycle-beat controller,
// each attached to its own behavioural async SRAM.
module tb_sram_ctrl_multibeat;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rd0 = 0, wr0 = 0, ready0, we0, oe0;
    logic [31:0] a0 = 0, wd0 = 0, rdata0;
    logic [17:0] sa0;
    wire  [15:0] dq0;
    logic        rd1 = 0, wr1 = 0, ready1, we1, oe1;
    logic [31:0] a1 = 0;
    logic [63:0] wd1 = 0, rdata1;
    logic [17:0] sa1;
    wire  [15:0] dq1;

    sram_ctrl_multibeat u0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(a0), .write_data(wd0),
        .read_data(rdata0), .ready(ready0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0)
    );

    sram_ctrl_multibeat #(.DATA_W(64), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(a1), .write_data(wd1),
        .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1)
    );

    logic [15:0] m0 [0:262143];
    logic [15:0] m1 [0:262143];
    assign dq0 = (!oe0 && we0) ? m0[sa0] : 16'hzzzz;
    assign dq1 = (!oe1 && we1) ? m1[sa1] : 16'hzzzz;
    always @(posedge clk) begin
        if (!we0) m0[sa0] <= dq0;
        if (!we1) m1[sa1] <= dq1;
    end

    logic        cur = 0;
    wire         w_rdy = cur ? ready1 : ready0;
    wire  [17:0] w_sa  = cur ? sa1 : sa0;
    wire         w_we  = cur ? we1 : we0;
    wire         w_oe  = cur ? oe1 : oe0;
    wire  [15:0] w_dq  = cur ? dq1 : dq0;
    wire  [63:0] w_rd  = cur ? rdata1 : {32'h0, rdata0};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] q[$];
    logic [63:0] last_rd [2];
    logic [15:0] sh [int];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [31:0] a, input logic [63:0] d);
        if (cur) begin
            rd1 = rd; wr1 = wr; a1 = a; wd1 = d;
        end else begin
            rd0 = rd; wr0 = wr; a0 = a; wd0 = d[31:0];
        end
    endtask

    // Issues one transaction at a negedge and checks every cycle against the beat schedule.
    task automatic txn(input logic wr, input logic rd, input logic [31:0] a, input logic [63:0] d, input int drop);
        int          beats, len, bt, wt, key;
        logic [17:0] base;
        logic [63:0] exp;
        beats = cur ? 4 : 2;
        len   = cur ? 4 : 2;
        base  = 18'(a >> 1);
        exp   = last_rd[cur];
        for (int i = 0; i < beats; i++) begin
            key = int'(cur) * 262144 + int'(18'(base + 18'(i)));
            if (wr) sh[key] = d[i*16 +: 16];
            else if (rd) exp[i*16 +: 16] = sh[key];
        end
        if (rd && !wr) last_rd[cur] = exp;
        q.push_back(exp);
        set_req(rd, wr, a, d);
        #1;
        check("req_ready", {63'h0, w_rdy}, 64'h0);
        for (int k = 1; k <= beats * len; k++) begin
            @(negedge clk);
            if (k == drop) set_req(0, 0, 0, 0);
            bt = (k - 1) / len;
            wt = (k - 1) % len;
            check("acc_ready", {63'h0, w_rdy}, 64'h0);
            check("addr", {46'h0, w_sa}, {46'h0, 18'(base + 18'(bt))});
            check("we_n", {63'h0, w_we}, {63'h0, !(wr && wt != len - 1)});
            check("oe_n", {63'h0, w_oe}, {63'h0, wr});
            if (wr) check("dq", {48'h0, w_dq}, {48'h0, d[bt*16 +: 16]});
        end
        @(negedge clk);
        check("done_ready", {63'h0, w_rdy}, 64'h1);
        check("done_we_n", {63'h0, w_we}, 64'h1);
        check("done_oe_n", {63'h0, w_oe}, 64'h1);
        check("read_data", w_rd, q.pop_front());
        set_req(0, 0, 0, 0);
        @(negedge clk);
        check("idle_ready", {63'h0, w_rdy}, 64'h1);
    endtask

    initial begin
        last_rd[0] = 0;
        last_rd[1] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        for (int s = 0; s < 2; s++) begin
            cur = s[0];
            #1;
            check("rst_ready", {63'h0, w_rdy}, 64'h1);
            check("rst_we_n", {63'h0, w_we}, 64'h1);
            check("rst_oe_n", {63'h0, w_oe}, 64'h1);
            check("rst_addr", {46'h0, w_sa}, 64'h0);
            check("rst_rdata", w_rd, 64'h0);
        end
        cur = 0;
        @(negedge clk);
        txn(1, 0, 32'h100, 64'hDEADBEEF, 0);
        txn(0, 1, 32'h100, 64'h0, 0);
        txn(1, 1, 32'h300, 64'h12345678, 0);
        txn(0, 1, 32'h300, 64'h0, 0);
        txn(0, 1, 32'h100, 64'h0, 1);
        // reset during beat 1 of a write
        set_req(0, 1, 32'h200, 64'hCAFEF00D);
        repeat (3) @(negedge clk);
        check("mid_addr", {46'h0, sa0}, 64'h101);
        check("mid_we_n", {63'h0, we0}, 64'h0);
        rst = 1;
        set_req(0, 0, 0, 0);
        @(negedge clk);
        check("rst2_we_n", {63'h0, we0}, 64'h1);
        check("rst2_oe_n", {63'h0, oe0}, 64'h1);
        check("rst2_addr", {46'h0, sa0}, 64'h0);
        check("rst2_rdata", {32'h0, rdata0}, 64'h0);
        rst = 0;
        #1;
        check("rst2_ready", {63'h0, ready0}, 64'h1);
        last_rd[0] = 0;
        @(negedge clk);
        txn(0, 1, 32'h100, 64'h0, 0);
        cur = 1;
        @(negedge clk);
        txn(1, 0, 32'h7FFFC, 64'h0123456789ABCDEF, 0);
        txn(0, 1, 32'h7FFFC, 64'h0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sram_ctrl_multibeat.md
# sram_ctrl_multibeat

Parametrised external-SRAM controller bridging the 32-bit memory stage to a narrow asynchronous SRAM. A DATA_W-bit access is split into DATA_W/SRAM_DQ_W sequential beats, each stretched by a configurable number of wait cycles. The memory stage is stalled through `ready` until the whole transaction completes. This block replaces the fixed 2-beat, fixed-6-cycle controller and adds configurable width and timing, latched requests, and an explicit output-enable.

## Interface
Parameters:
- DATA_W, 32, requester data width; an integer multiple of SRAM_DQ_W.
- SRAM_DQ_W, 16, SRAM data bus width; a multiple of 8.
- SRAM_ADDR_W, 18, SRAM word-address width.
- WAIT_CYCLES, 1, extra cycles per beat (minimum 1); beat length is L = WAIT_CYCLES+1.
- Derived: BEATS = DATA_W/SRAM_DQ_W; BYTE_SHIFT = log2(SRAM_DQ_W/8).

Ports:
- clk, input, 1, single clock. One clock; reset is synchronous and active-high.
- rst, input, 1, synchronous active-high reset.
- rd_en, input, 1, read request; held by the requester until `ready`.
- wr_en, input, 1, write request; wins over rd_en when both are high.
- address, input, 32, byte address.
- write_data, input, DATA_W, write payload.
- read_data, output, DATA_W, read result; beat 0 is in the LSBs.
- ready, output, 1, transaction complete / controller free.
- SRAM_DQ, inout, SRAM_DQ_W, SRAM data bus.
- SRAM_ADDR, output, SRAM_ADDR_W, registered word address.
- SRAM_WE_N, output, 1, write enable, active low.
- SRAM_OE_N, output, 1, output enable, active low.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:** if wr_en|rd_en, latch the op (write priority), `address`, and `write_data`; load the beat counter b=0 and the wait counter w=0; go to ACCESS.
- **ACCESS:** w counts 0..L-1. At w=L-1, if b=BEATS-1 go to DONE; otherwise b++ and w=0.
- **DONE:** ready=1 for exactly one cycle; go to IDLE.
- **Address per beat:** SRAM_ADDR = (latched_address >> BYTE_SHIFT)[SRAM_ADDR_W-1:0] + b, modulo 2^SRAM_ADDR_W (wraps silently). It is registered, updated on entry to each beat, and holds its value in IDLE/DONE.
- **Write beat:**
  - SRAM_DQ driven with write_data slice b for all L cycles.
  - SRAM_WE_N=0 for w=0..L-2 and 1 at w=L-1 (data hold).
  - SRAM_OE_N=1.
- **Read beat:**
  - SRAM_DQ is hi-Z; SRAM_WE_N=1; SRAM_OE_N=0.
  - SRAM_DQ is sampled into read_data slice b at w=L-1.
- **Outside ACCESS:** SRAM_DQ is hi-Z and SRAM_WE_N=SRAM_OE_N=1.
- **read_data:** updated only by read beats; holds its value otherwise, including across writes.
- **ready:**
  - IDLE: ready = !(rd_en|wr_en).
  - ACCESS: ready=0.
  - DONE: ready=1.
- **Request dropped or changed mid-transaction:** ignored; the latched transaction completes and DONE still pulses.
- **Reset:** synchronous; overrides everything, including mid-transaction. The next cycle is IDLE with SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ hi-Z, SRAM_ADDR=0, read_data=0, b=w=0. An interrupted write may leave SRAM partially updated; that is acceptable.

## Timing
- A request seen in IDLE at cycle t gives ACCESS from t+1 to t+BEATS·L, and DONE (ready=1) at t+BEATS·L+1.
- Total stall = BEATS·L+2 cycles including the request cycle. Defaults: 2·2+2 = 6.
- Read data is valid from the DONE cycle onward, and stable until the next read's beat-0 sample.
- Back-to-back transactions: the requester advances on ready in DONE; the next request is accepted in the following IDLE cycle. There is one dead cycle per transaction and no pipelining.
- SRAM_WE_N and SRAM_OE_N are registered with SRAM_ADDR, so the address is stable for the whole beat.
- At every WE_N rising edge, address and data remain stable for at least one further cycle.

## Structure
- Package `sram_ctrl_pkg`:
  - state enum {IDLE, ACCESS, DONE};
  - op enum {OP_RD, OP_WR};
  - function clog2 for BYTE_SHIFT and counter widths.
- Sub-module `sram_beat_timer`: wait counter plus beat counter. Inputs: start, BEATS, L. Outputs: b, w, beat_last_cycle, txn_last_cycle.
- Top level holds the FSM, request latches, tri-state DQ driver, and read assembly.

## Test plan
- **Default write:** write 0xDEADBEEF to address 0x100.
  - SRAM_ADDR 0x80 then 0x81; DQ 0xBEEF then 0xDEAD.
  - WE_N low for 1 cycle per beat.
  - ready at cycle t+5.
- **Default read-back:** read from 0x100 with the SRAM model → read_data=0xDEADBEEF in the DONE cycle; ready low for cycles t..t+4.
- **Wrap-around:** DATA_W=64, WAIT_CYCLES=3, address 0x7FFFC, SRAM_ADDR_W=18 → SRAM_ADDR 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; each beat lasts 4 cycles; ready at t+17.
- **Simultaneous rd_en and wr_en:** both high → write performed; read_data unchanged; DONE pulses once.
- **Request drop:** rd_en is dropped after cycle t+1 → the transaction still completes; DONE ready=1; FSM returns to IDLE.
- **Reset mid-transaction:** assert rst during beat 1 of a write → next cycle WE_N=1, OE_N=1, DQ hi-Z, SRAM_ADDR=0, read_data=0, IDLE; a new read then completes normally in 6 cycles.
